dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Data-memory controller between the pipeline's Memory stage and an external word-wide memory bus with a req/ack handshake. Stores are retired into a small posted store buffer without stalling. Loads are forwarded from that buffer or fetched over the bus. `stall_m` goes to the hazard unit and freezes the pipeline while a load miss or a full-buffer store is pending.

## Interface
- `DEPTH`, default 4: store-buffer entries; power of 2, at least 2.
- `clk` in, 1 bit: system clock; all state updates on the rising edge.
- `rst` in, 1 bit: one clock; reset is synchronous and active-high.
- `mem_write_m` in, 1 bit: M-stage store (`MemWriteM`).
- `mem_read_m` in, 1 bit: M-stage load (`ResultSrcM == 2'b01`).
- `addr_m` in, 32 bits: byte address (`ALUResultM`); bits [1:0] ignored, word access only.
- `wdata_m` in, 32 bits: store data (`WriteDataM`).
- `rdata_m` out, 32 bits: load data (`ReadDataM`).
- `stall_m` out, 1 bit: freeze F/D/E/M; M inputs are held stable while high.
- `bus_req` out, 1 bit: transfer request.
- `bus_we` out, 1 bit: 1 = write, 0 = read.
- `bus_addr` out, 32 bits: word address, {addr[31:2], 2'b00}.
- `bus_wdata` out, 32 bits: write data.
- `bus_ack` in, 1 bit: transfer complete; sampled only while `bus_req` = 1.
- `bus_rdata` in, 32 bits: read data, valid in the `bus_ack` cycle.

## Operation
- Store buffer: circular FIFO of {word address [31:2], data [31:0]}, with head/tail pointers and a count of 0..DEPTH.
- Store, with `stall_m` = 0 and count < DEPTH: enqueue at tail in the same edge.
- Store with count == DEPTH: `stall_m` = 1 and no enqueue. This holds even if a pop happens in the same cycle; fullness uses the registered count.
- `mem_read_m` and `mem_write_m` both high: treated as a store.
- Load forward hit (any valid entry matches addr[31:2], youngest wins): `rdata_m` = entry data combinationally, `stall_m` = 0, no bus access. This includes the entry currently being drained.
- Load miss: a bus read, with priority over the next drain.
- FSM states:
  - S_IDLE: no transfer.
  - S_WR: draining the head entry.
  - S_RD: load read in flight.
  - S_RESP: returning load data.
- S_IDLE:
  - Load miss: `stall_m` = 1, go to S_RD.
  - Else if count > 0: go to S_WR.
- S_WR: `bus_req` = 1, `bus_we` = 1, address/data from head.
  - On `bus_ack`: pop head, go to S_IDLE.
  - A load miss arriving during S_WR stalls until the ack, then S_IDLE issues it.
- S_RD: `bus_req` = 1, `bus_we` = 0, `stall_m` = 1.
  - On `bus_ack`: latch `bus_rdata` into the response register, go to S_RESP.
- S_RESP: `rdata_m` = response register, `stall_m` = 0 (pipeline advances); go to S_IDLE next edge. The held load is never reissued.
- `rdata_m` = 32'h0 when there is no load or the load is stalled.
- Bus outputs come from registered state (Moore). Address, data and `bus_we` stay stable from request until the ack edge. `bus_ack` while `bus_req` = 0 is ignored.

## Timing
- Reset values: `bus_req` = 0, `bus_we` = 0, `bus_addr` = 0, `bus_wdata` = 0, `rdata_m` = 0, `stall_m` = 0; state S_IDLE; count, head and tail = 0.
- Reset mid-transfer: the transfer is abandoned, buffered stores are discarded, and `bus_req` = 0 from the edge after `rst` is sampled.
- Store, buffer not full: zero stall cycles.
- Drain: `bus_req` rises one cycle after the entry becomes head in S_IDLE.
- Minimum gap between drains is one S_IDLE cycle.
- Load miss with the bus idle and ack in the first S_RD cycle: `stall_m` high for 2 cycles (S_IDLE, S_RD); data in cycle 3 (S_RESP). Each bus wait cycle adds 1.
- Load miss behind an in-flight drain: add the remaining S_WR cycles plus 1 S_IDLE cycle.
- Count, head and tail update only on enqueue (tail) and ack-pop (head). Pointers wrap modulo DEPTH.

## Structure
- Package `dmem_pkg`:
  - `dmem_state_t` enum: S_IDLE, S_WR, S_RD, S_RESP.
  - `sb_entry_t` packed struct {logic [29:0] waddr; logic [31:0] data;}.
- Sub-module `store_buf`:
  - FIFO with full/empty, push/pop and head outputs.
  - Parallel address-compare lookup returning hit plus youngest-match data.
- The top holds the FSM, response register and bus drivers.

## Test plan
- Reset, then idle: all outputs 0; `bus_req` stays 0 with an empty buffer.
- Store 0xDEADBEEF to 0x100, ack after 2 wait cycles: no stall. Bus sees `bus_we` = 1, `bus_addr` 0x100, data 0xDEADBEEF, held stable until ack; count returns to 0.
- Stores to 0x100 (0x11) then 0x100 (0x22), with the bus acking never: the load from 0x102 forwards 0x22 with no stall.
- Five stores with `bus_ack` held low: `stall_m` = 1 on the fifth. Releasing ack drains in FIFO order and the fifth enqueues the cycle after the first pop.
- Load miss at 0x200 with `bus_rdata` = 0xCAFEF00D, immediate ack: `stall_m` = 1 for 2 cycles, then `rdata_m` = 0xCAFEF00D with `stall_m` = 0 for exactly one cycle.
- `rst` asserted during S_RD with stores buffered: `bus_req` drops next cycle and count = 0. A subsequent load to a previously buffered address misses and goes to the bus.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory controller: FSM state encoding and
// store-buffer entry layout.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RESP
  } dmem_state_t;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
  } sb_entry_t;

  function automatic logic [31:0] byte_addr(input logic [29:0] waddr);
    return {waddr, 2'b00};
  endfunction

endpackage

// File: rtl/dmem_store_buf.sv
// Posted store buffer: circular FIFO of word stores plus a parallel
// address lookup that returns the youngest matching entry.
module store_buf
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  sb_entry_t   push_entry,
  input  logic        pop,
  input  logic [29:0] lk_waddr,
  output logic        full,
  output logic        empty,
  output sb_entry_t   head_entry,
  output logic        lk_hit,
  output logic [31:0] lk_data
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t        mem [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [PW:0]      count;
  logic [DEPTH-1:0] vld, match;
  logic             push_ok, pop_ok;

  assign full       = (count == (PW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign push_ok    = push & ~full;
  assign pop_ok     = pop & ~empty;
  assign head_entry = mem[head];

  // Slot validity comes from its distance behind head, so no per-slot flags.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PW-1:0] age;
    assign age      = PW'(i) - head;
    assign vld[i]   = ({1'b0, age} < count);
    assign match[i] = vld[i] && (mem[i].waddr == lk_waddr);
  end

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (match[idx]) begin
        lk_hit  = 1'b1;
        lk_data = mem[idx].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + 1'b1;
      if (pop_ok)  head <= head + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[tail] <= push_entry;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Memory-stage data controller: posted stores drain over a req/ack bus,
// loads forward from the store buffer or fetch with a stall.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write_m,
  input  logic        mem_read_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  output logic [31:0] rdata_m,
  output logic        stall_m,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  dmem_state_t state, state_nxt;
  sb_entry_t   head_e, push_e;
  logic        st, ld, ld_miss, push, pop;
  logic        sb_full, sb_empty, lk_hit;
  logic [31:0] lk_data, resp_q;
  logic        unused_lsb;

  assign unused_lsb = ^addr_m[1:0];

  // A simultaneous read+write is a store.
  assign st      = mem_write_m;
  assign ld      = mem_read_m & ~mem_write_m;
  assign ld_miss = ld & ~lk_hit;
  assign push    = st & ~sb_full;
  assign pop     = (state == S_WR) & bus_ack;
  assign push_e  = '{waddr: addr_m[31:2], data: wdata_m};

  store_buf #(.DEPTH(DEPTH)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_entry(push_e),
    .pop       (pop),
    .lk_waddr  (addr_m[31:2]),
    .full      (sb_full),
    .empty     (sb_empty),
    .head_entry(head_e),
    .lk_hit    (lk_hit),
    .lk_data   (lk_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_m   = st & sb_full;
    rdata_m   = '0;
    case (state)
      S_IDLE: begin
        if (ld_miss)        state_nxt = S_RD;
        else if (!sb_empty) state_nxt = S_WR;
      end
      S_WR:    if (bus_ack) state_nxt = S_IDLE;
      S_RD:    if (bus_ack) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // The held load is answered from resp_q in S_RESP and never reissued.
    if (ld) begin
      if (state == S_RESP) rdata_m = resp_q;
      else if (state == S_RD) stall_m = 1'b1;
      else if (lk_hit) rdata_m = lk_data;
      else stall_m = 1'b1;
    end
  end

  // Bus side is registered so address/data stay frozen until the ack edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      resp_q    <= '0;
    end else begin
      if (state == S_RD && bus_ack) resp_q <= bus_rdata;
      if (state == S_IDLE && state_nxt == S_WR) begin
        bus_req   <= 1'b1;
        bus_we    <= 1'b1;
        bus_addr  <= byte_addr(head_e.waddr);
        bus_wdata <= head_e.data;
      end else if (state == S_IDLE && state_nxt == S_RD) begin
        bus_req  <= 1'b1;
        bus_we   <= 1'b0;
        bus_addr <= {addr_m[31:2], 2'b00};
      end else if ((state == S_WR || state == S_RD) && bus_ack) begin
        bus_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios with literal
// expectations, then random traffic against a transaction-level model.
module tb_dmem_ctrl;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
  } ent_t;

  logic        clk, rst;
  logic        mem_write_m, mem_read_m;
  logic [31:0] addr_m, wdata_m, rdata_m;
  logic        stall_m, bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int n_pass = 0;
  int n_tot  = 0;
  logic chk_en = 1'b0;

  // model: pending stores, one outstanding bus transfer, one-cycle response
  ent_t        sbq[$];
  int          xfer;          // 0 none, 1 write, 2 read
  logic [31:0] x_addr, x_data;
  logic        resp_v;
  logic [31:0] resp_d;

  dmem_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_write_m(mem_write_m), .mem_read_m(mem_read_m),
    .addr_m(addr_m), .wdata_m(wdata_m),
    .rdata_m(rdata_m), .stall_m(stall_m),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic void lookup(input logic [31:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].waddr == a[31:2]) begin
        h = 1'b1;
        d = sbq[i].data;
        break;
      end
    end
  endfunction

  function automatic void model_eval(output logic s, output logic [31:0] r);
    logic h;
    logic [31:0] d;
    s = 1'b0;
    r = '0;
    lookup(addr_m, h, d);
    if (mem_write_m) s = (sbq.size() == DEPTH);
    else if (mem_read_m) begin
      if (resp_v)   r = resp_d;
      else if (h)   r = d;
      else          s = 1'b1;
    end
  endfunction

  task automatic model_step();
    logic h, st, ld, popq;
    logic [31:0] d;
    int n;
    if (rst) begin
      sbq.delete();
      xfer = 0; resp_v = 1'b0; x_addr = '0; x_data = '0; resp_d = '0;
      return;
    end
    st   = mem_write_m;
    ld   = mem_read_m & ~mem_write_m;
    popq = 1'b0;
    n    = sbq.size();
    lookup(addr_m, h, d);
    if (resp_v) resp_v = 1'b0;
    else if (xfer != 0) begin
      if (bus_ack) begin
        if (xfer == 1) popq = 1'b1;
        else begin resp_v = 1'b1; resp_d = bus_rdata; end
        xfer = 0;
      end
    end else if (ld && !h) begin
      xfer = 2; x_addr = {addr_m[31:2], 2'b00};
    end else if (n > 0) begin
      xfer = 1; x_addr = {sbq[0].waddr, 2'b00}; x_data = sbq[0].data;
    end
    if (st && n < DEPTH) sbq.push_back('{waddr: addr_m[31:2], data: wdata_m});
    if (popq) void'(sbq.pop_front());
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    logic es;
    logic [31:0] er;
    if (chk_en && !rst) begin
      model_eval(es, er);
      chk("m_stall", stall_m, es);
      chk("m_rdata", rdata_m, er);
      chk("m_req", bus_req, xfer != 0);
      if (xfer != 0) begin
        chk("m_we", bus_we, xfer == 1);
        chk("m_addr", bus_addr, x_addr);
        if (xfer == 1) chk("m_wdata", bus_wdata, x_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    mem_write_m = w; mem_read_m = r; addr_m = a; wdata_m = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_a [4];
    logic        hold, was_rst;
    logic [31:0] tmp;
    int          k;
    rst = 1'b1; bus_ack = 1'b0; bus_rdata = '0;
    drive(0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0; chk_en = 1'b1;

    // reset state and idle
    @(negedge clk);
    chk("rst_req", bus_req, 0);  chk("rst_we", bus_we, 0);
    chk("rst_addr", bus_addr, 0); chk("rst_wdata", bus_wdata, 0);
    chk("rst_rdata", rdata_m, 0); chk("rst_stall", stall_m, 0);
    for (int i = 0; i < 3; i++) begin tick(); @(negedge clk); chk("idle_req", bus_req, 0); end

    // single store, ack after two wait cycles
    tick(); drive(1, 0, 32'h100, 32'hDEADBEEF);
    @(negedge clk); chk("st_stall", stall_m, 0);
    tick(); drive(0, 0, 0, 0);
    @(negedge clk); chk("st_req_lat", bus_req, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) bus_ack = 1'b1;
      @(negedge clk);
      chk("st_req", bus_req, 1); chk("st_we", bus_we, 1);
      chk("st_addr", bus_addr, 32'h100); chk("st_wdata", bus_wdata, 32'hDEADBEEF);
    end
    tick(); bus_ack = 1'b0;
    @(negedge clk); chk("st_done", bus_req, 0);
    tick(); @(negedge clk); chk("st_empty", bus_req, 0);

    // youngest-match forwarding while the bus never acks
    tick(); drive(1, 0, 32'h100, 32'h11);
    @(negedge clk); tick(); drive(1, 0, 32'h100, 32'h22);
    @(negedge clk); tick(); drive(0, 1, 32'h102, 0);
    @(negedge clk); chk("fwd_data", rdata_m, 32'h22); chk("fwd_stall", stall_m, 0);
    tick(); drive(0, 0, 0, 0); bus_ack = 1'b1;
    repeat (8) tick();
    bus_ack = 1'b0;

    // fill the buffer, fifth store stalls until the first pop
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i));
      @(negedge clk); chk("fill_stall", stall_m, 0);
      tick();
    end
    drive(1, 0, 32'h310, 32'hA4);
    @(negedge clk); chk("full_stall", stall_m, 1);
    tick(); bus_ack = 1'b1;
    @(negedge clk); chk("full_hold", stall_m, 1);
    chk("head_addr", bus_addr, 32'h300); chk("head_data", bus_wdata, 32'hA0);
    tick();
    @(negedge clk); chk("fifth_enq", stall_m, 0);
    tick(); drive(0, 0, 0, 0);
    exp_a = '{32'h304, 32'h308, 32'h30C, 32'h310};
    k = 0;
    for (int c = 0; c < 30 && k < 4; c++) begin
      @(negedge clk);
      if (bus_req && bus_we) begin
        chk("drain_addr", bus_addr, exp_a[k]);
        chk("drain_data", bus_wdata, 32'hA1 + 32'(k));
        k++;
      end
      tick();
    end
    chk("drain_cnt", k, 4);
    tick(); tick();

    // load miss, immediate ack
    bus_rdata = 32'hCAFEF00D;
    drive(0, 1, 32'h200, 0);
    @(negedge clk); chk("ld_stall1", stall_m, 1); chk("ld_rd1", rdata_m, 0); chk("ld_req1", bus_req, 0);
    tick();
    @(negedge clk); chk("ld_stall2", stall_m, 1); chk("ld_req2", bus_req, 1);
    chk("ld_we", bus_we, 0); chk("ld_addr", bus_addr, 32'h200);
    tick();
    @(negedge clk); chk("ld_data", rdata_m, 32'hCAFEF00D); chk("ld_stall3", stall_m, 0);
    tick(); drive(0, 0, 0, 0);
    @(negedge clk); chk("ld_once", rdata_m, 0); chk("ld_idle", bus_req, 0);

    // reset during a bus read with a store buffered
    tick(); bus_ack = 1'b0; drive(1, 0, 32'h400, 32'h55);
    @(negedge clk); tick(); drive(0, 1, 32'h500, 0);
    @(negedge clk); chk("rr_stall", stall_m, 1);
    tick();
    @(negedge clk); chk("rr_req", bus_req, 1);
    #1 rst = 1'b1;
    tick(); rst = 1'b0; drive(0, 0, 0, 0);
    @(negedge clk); chk("rr_drop", bus_req, 0);
    tick(); drive(0, 1, 32'h400, 0); bus_ack = 1'b1; bus_rdata = 32'h12345678;
    @(negedge clk); chk("rr_miss", stall_m, 1);
    tick();
    @(negedge clk); chk("rr_rdreq", bus_req, 1); chk("rr_addr", bus_addr, 32'h400); chk("rr_we", bus_we, 0);
    tick();
    @(negedge clk); chk("rr_data", rdata_m, 32'h12345678);
    tick(); drive(0, 0, 0, 0);

    // random traffic against the model
    was_rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      model_eval(hold, tmp);
      tick();
      was_rst = rst;
      rst = ($urandom_range(0, 599) == 0);
      bus_ack = ($urandom_range(0, 2) != 0);
      bus_rdata = $urandom;
      if (!hold || was_rst) begin
        case ($urandom_range(0, 3))
          0: drive(0, 0, $urandom, $urandom);
          1: drive(1, 0, 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)), $urandom);
          2: drive(0, 1, 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)), $urandom);
          default: drive(1, 1, 32'h100 + 32'($urandom_range(0, 7) * 4), $urandom);
        endcase
      end
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
